// File: rtl/hamming74_encoder_tx.sv
// hamming74_encoder_tx
// Transmit side of the decoder_proj link. Nibbles are buffered in a small
// circular FIFO, encoded to Hamming(7,4) codewords and shifted out on one
// serial line framed as: start bit (0), code bits LSB first, stop bit (1).
// Define HAMMING_SECDED_EN to append an overall even-parity bit (8-bit code,
// 10-bit frame); left undefined the block sends plain 7-bit codewords.
module hamming74_encoder_tx #(
   parameter int DEPTH   = 4,
   parameter int BIT_DIV = 4,
`ifdef HAMMING_SECDED_EN
   localparam int CW = 8
`else
   localparam int CW = 7
`endif
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_data,
   output logic                     tx_serial,
   output logic                     tx_busy,
   output logic                     frame_done,
   output logic [CW-1:0]            code_out,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic [DW-1:0]   div_cnt, div_n;
   logic [2:0]      bit_cnt, bit_n;
   logic [CW-1:0]   shift_reg, shift_n;
   logic [CW-1:0]   code_n;
   logic            tx_n, busy_n, done_n;

   logic [3:0]      mem [DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            full, empty, push, pop, last_tick;
   logic [3:0]      head;
   logic [CW-1:0]   head_code;

   // Hamming(7,4): c = {d4,d3,d2,p4,d1,p2,p1}, optionally with overall parity on top
   function automatic logic [CW-1:0] encode(input logic [3:0] d);
      logic [6:0] c;
      c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
`ifdef HAMMING_SECDED_EN
      return {^c, c};
`else
      return c;
`endif
   endfunction

   // The extra pointer bit distinguishes full from empty when the indices match
   assign fifo_level = wr_ptr - rd_ptr;
   assign full       = (fifo_level == PW'(DEPTH));
   assign empty      = (wr_ptr == rd_ptr);
   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign head_code  = encode(head);
   assign last_tick  = (div_cnt == DW'(BIT_DIV - 1));

   // Storage array has no reset; only the pointers define what is valid
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= in_data;
   end

   // FIFO pointers advance on accepted pushes and on pops issued by the FSM
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Next-state logic; line outputs are derived from the next state so they are registered
   always_comb begin
      state_n = state;
      div_n   = div_cnt;
      bit_n   = bit_cnt;
      shift_n = shift_reg;
      code_n  = code_out;
      pop     = 1'b0;
      tx_n    = 1'b1;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head_code;
               code_n  = head_code;
               div_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (last_tick) begin
               div_n   = '0;
               bit_n   = '0;
               state_n = DATA;
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         DATA: begin
            if (last_tick) begin
               div_n   = '0;
               shift_n = shift_reg >> 1;
               if (bit_cnt == 3'(CW - 1))
                  state_n = STOP;
               else
                  bit_n = bit_cnt + 1'b1;
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         STOP: begin
            if (last_tick) begin
               div_n = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = head_code;
                  code_n  = head_code;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               div_n = div_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            div_n   = '0;
         end
      endcase
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
      busy_n = (state_n != IDLE);
      done_n = (state_n == STOP) && (div_n == DW'(BIT_DIV - 1));
   end

   // State and output registers; reset forces the line idle high immediately
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         code_out   <= '0;
         tx_serial  <= 1'b1;
         tx_busy    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         div_cnt    <= div_n;
         bit_cnt    <= bit_n;
         shift_reg  <= shift_n;
         code_out   <= code_n;
         tx_serial  <= tx_n;
         tx_busy    <= busy_n;
         frame_done <= done_n;
      end
   end

endmodule

// File: tb/tb_hamming74_encoder_tx.sv
// tb_hamming74_encoder_tx
// Directed bench for hamming74_encoder_tx at DEPTH=4, BIT_DIV=4.
// Honours HAMMING_SECDED_EN the same way as the design.
module tb_hamming74_encoder_tx;

   localparam int DEPTH   = 4;
   localparam int BIT_DIV = 4;
`ifdef HAMMING_SECDED_EN
   localparam int CW = 8;
`else
   localparam int CW = 7;
`endif
   localparam int FL = (CW + 2) * BIT_DIV;

   // Hand-computed Hamming(7,4) codewords for nibbles 0..F
   localparam logic [6:0] HAM_TABLE [16] = '{
      7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
      7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

   logic            clock;
   logic            reset;
   logic            inValid;
   logic            inReady;
   logic [3:0]      inData;
   logic            txSerial;
   logic            txBusy;
   logic            frameDone;
   logic [CW-1:0]   codeOut;
   logic [2:0]      fifoLevel;

   int testsRun;
   int testsFailed;

   hamming74_encoder_tx #(.DEPTH(DEPTH), .BIT_DIV(BIT_DIV)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_data    (inData),
      .tx_serial  (txSerial),
      .tx_busy    (txBusy),
      .frame_done (frameDone),
      .code_out   (codeOut),
      .fifo_level (fifoLevel)
   );

   // Free-running clock, 10 time units per period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [CW-1:0] expCode(input logic [3:0] n);
      logic [6:0] t;
      t = HAM_TABLE[n];
`ifdef HAMMING_SECDED_EN
      return {^t, t};
`else
      return t;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Offer one nibble from a falling edge until it is taken, then drop valid
   task automatic applyStimulus(input logic [3:0] nib);
      int waits;
      waits   = 0;
      inValid = 1'b1;
      inData  = nib;
      while (inReady !== 1'b1 && waits < 200) begin
         @(negedge clock);
         waits++;
      end
      if (inReady !== 1'b1) begin
         checkOutput("push_timeout", 32'(0), 32'(1));
         inValid = 1'b0;
         return;
      end
      @(posedge clock);
      @(negedge clock);
      inValid = 1'b0;
   endtask

   // Waits for a start bit, records a whole frame and checks its shape
   task automatic captureFrame(output logic [CW-1:0] code, output int errs, output int gap);
      logic ln [FL];
      logic fd [FL];
      logic bz [FL];
      int   waits;
      code  = '0;
      errs  = 0;
      gap   = 0;
      waits = 0;
      do begin
         @(negedge clock);
         waits++;
      end while (txSerial !== 1'b0 && waits < 200);
      if (txSerial !== 1'b0) begin
         checkOutput("start_timeout", 32'(0), 32'(1));
         errs = 1;
         return;
      end
      gap = waits - 1;
      for (int i = 0; i < FL; i++) begin
         if (i > 0)
            @(negedge clock);
         ln[i] = txSerial;
         fd[i] = frameDone;
         bz[i] = txBusy;
      end
      for (int b = 0; b < CW + 2; b++)
         for (int j = 0; j < BIT_DIV; j++)
            if (ln[b * BIT_DIV + j] !== ln[b * BIT_DIV])
               errs++;
      if (ln[0] !== 1'b0)
         errs++;
      if (ln[FL - 1] !== 1'b1)
         errs++;
      for (int i = 0; i < FL; i++) begin
         if (fd[i] !== (i == FL - 1))
            errs++;
         if (bz[i] !== 1'b1)
            errs++;
      end
      for (int k = 0; k < CW; k++)
         code[k] = ln[(k + 1) * BIT_DIV];
   endtask

   task automatic verifyFrame(input string tag, input logic [3:0] nib, input logic checkGap);
      logic [CW-1:0] code;
      int errs;
      int gap;
      captureFrame(code, errs, gap);
      checkOutput({tag, "_serial_code"}, 32'(code), 32'(expCode(nib)));
      checkOutput({tag, "_code_out"}, 32'(codeOut), 32'(expCode(nib)));
      checkOutput({tag, "_frame_shape_errs"}, 32'(errs), 32'(0));
      if (checkGap)
         checkOutput({tag, "_gap"}, 32'(gap), 32'(0));
   endtask

   initial begin
      logic [3:0] burstA [5];
      logic [3:0] burstB [6];
      burstA = '{4'hB, 4'h1, 4'h2, 4'h4, 4'h8};
      burstB = '{4'hC, 4'h3, 4'h5, 4'h6, 4'h9, 4'hA};
      testsRun    = 0;
      testsFailed = 0;
      reset   = 1'b1;
      inValid = 1'b0;
      inData  = 4'h0;

      repeat (2) @(negedge clock);
      checkOutput("rst_tx_serial", 32'(txSerial), 32'(1));
      checkOutput("rst_tx_busy", 32'(txBusy), 32'(0));
      checkOutput("rst_frame_done", 32'(frameDone), 32'(0));
      checkOutput("rst_code_out", 32'(codeOut), 32'(0));
      checkOutput("rst_fifo_level", 32'(fifoLevel), 32'(0));
      checkOutput("rst_in_ready", 32'(inReady), 32'(1));
      reset = 1'b0;
      @(negedge clock);

      $display("[TB] single 0xB frame");
      applyStimulus(4'hB);
      verifyFrame("single_b", 4'hB, 1'b1);
      @(negedge clock);
      checkOutput("single_idle_busy", 32'(txBusy), 32'(0));
      checkOutput("single_idle_line", 32'(txSerial), 32'(1));
      checkOutput("single_idle_done", 32'(frameDone), 32'(0));

      $display("[TB] all sixteen nibbles");
      for (int n = 0; n < 16; n++) begin
         applyStimulus(4'(n));
         verifyFrame($sformatf("nib_%0h", n), 4'(n), 1'b1);
      end

      $display("[TB] launch plus four back-to-back pushes");
      fork
         begin
            for (int k = 0; k < 5; k++)
               applyStimulus(burstA[k]);
            checkOutput("burst_full_level", 32'(fifoLevel), 32'(4));
            checkOutput("burst_full_ready", 32'(inReady), 32'(0));
         end
         begin
            for (int k = 0; k < 5; k++) begin
               verifyFrame($sformatf("burst_%0d", k), burstA[k], k > 0);
               checkOutput($sformatf("burst_level_%0d", k), 32'(fifoLevel), 32'(4 - k));
               checkOutput($sformatf("burst_ready_%0d", k), 32'(inReady), (k == 0) ? 32'(0) : 32'(1));
            end
         end
      join

      $display("[TB] push refused while full during pop");
      fork
         begin
            int waits;
            for (int k = 0; k < 5; k++)
               applyStimulus(burstB[k]);
            inValid = 1'b1;
            inData  = burstB[5];
            waits   = 0;
            while (frameDone !== 1'b1 && waits < 100) begin
               @(negedge clock);
               waits++;
            end
            checkOutput("full_pop_frame_done", 32'(frameDone), 32'(1));
            checkOutput("full_pop_ready_before", 32'(inReady), 32'(0));
            checkOutput("full_pop_level_before", 32'(fifoLevel), 32'(4));
            @(negedge clock);
            checkOutput("full_pop_refused_level", 32'(fifoLevel), 32'(3));
            checkOutput("full_pop_ready_after", 32'(inReady), 32'(1));
            @(negedge clock);
            checkOutput("full_pop_accepted_level", 32'(fifoLevel), 32'(4));
            inValid = 1'b0;
         end
         begin
            for (int k = 0; k < 6; k++)
               verifyFrame($sformatf("wrap_%0d", k), burstB[k], k > 0);
            checkOutput("wrap_final_level", 32'(fifoLevel), 32'(0));
         end
      join

      $display("[TB] reset during data bit 3");
      @(negedge clock);
      applyStimulus(4'hB);
      applyStimulus(4'h5);
      applyStimulus(4'h7);
      repeat (16) @(negedge clock);
      checkOutput("mid_reset_pre_line", 32'(txSerial), 32'(0));
      checkOutput("mid_reset_pre_busy", 32'(txBusy), 32'(1));
      checkOutput("mid_reset_pre_level", 32'(fifoLevel), 32'(2));
      reset = 1'b1;
      #1;
      checkOutput("mid_reset_line", 32'(txSerial), 32'(1));
      checkOutput("mid_reset_level", 32'(fifoLevel), 32'(0));
      checkOutput("mid_reset_busy", 32'(txBusy), 32'(0));
      checkOutput("mid_reset_ready", 32'(inReady), 32'(1));
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(4'h6);
      verifyFrame("post_reset", 4'h6, 1'b1);
      @(negedge clock);
      checkOutput("post_reset_idle", 32'(txBusy), 32'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
